// File: rtl/ds1302_rtc_sequencer.sv
// DS1302 command sequencer: WP clear, periodic clock-register poll, host arbitration.
// Define RTC_SEQ_TIMEOUT_EN to bound engine waits by TIMEOUT and drive o_err.
module ds1302_rtc_sequencer #(
    parameter int POLL_DIV = 1_000_000,
    parameter int TIMEOUT  = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_host_req,
    input  logic        i_host_rd,
    input  logic [4:0]  i_host_addr,
    input  logic        i_host_rc,
    input  logic [7:0]  i_host_wdata,
    output logic        o_host_ack,
    output logic [7:0]  o_host_rdata,
    output logic        o_eng_wr_en,
    output logic        o_eng_rd_en,
    output logic [4:0]  o_eng_addr,
    output logic        o_eng_rc,
    output logic [7:0]  o_eng_wdata,
    input  logic        i_eng_wr_done,
    input  logic        i_eng_rd_done,
    input  logic [7:0]  i_eng_rd_data,
    output logic [55:0] o_time,
    output logic        o_time_valid,
    output logic        o_halted,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_NEXT
    } state_t;

    typedef enum logic [1:0] {
        K_INIT, K_HOST, K_POLL
    } kind_t;

    localparam int PW = $clog2(POLL_DIV);

    state_t          state, state_nx;
    kind_t           kind;
    logic            cmd_wr;
    logic [2:0]      idx;
    logic            gap_cnt;
    logic            aborted;
    logic [5:0][7:0] shadow;
    logic [PW-1:0]   poll_cnt;
    logic            poll_pend;
    logic            wr_done_q, rd_done_q;

    logic start_host, start_poll, step_poll;
    logic done_hit, time_out, snap_load;
    logic done_edge, wait_expired;
    logic poll_wrap, in_burst;

    // Only the done line matching the issued command counts, on its rising edge.
    assign done_edge = cmd_wr ? (i_eng_wr_done & ~wr_done_q)
                              : (i_eng_rd_done & ~rd_done_q);

    assign poll_wrap = i_enable && (poll_cnt == PW'(POLL_DIV - 1));
    assign in_burst  = (kind == K_POLL) && (state != S_IDLE);
    assign snap_load = done_hit && (kind == K_POLL) && (idx == 3'd6);

    assign o_eng_wr_en = (state == S_ISSUE) &&  cmd_wr;
    assign o_eng_rd_en = (state == S_ISSUE) && !cmd_wr;
    assign o_halted    = o_time[7];

    always_comb begin
        state_nx   = state;
        start_host = 1'b0;
        start_poll = 1'b0;
        step_poll  = 1'b0;
        done_hit   = 1'b0;
        time_out   = 1'b0;
        unique case (state)
            S_INIT:  state_nx = S_ISSUE;
            S_IDLE: begin
                if (i_host_req) begin
                    start_host = 1'b1;
                    state_nx   = S_ISSUE;
                end else if (poll_pend && i_enable) begin
                    start_poll = 1'b1;
                    state_nx   = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (done_edge) begin
                    done_hit = 1'b1;
                    state_nx = S_GAP;
                end else if (wait_expired) begin
                    time_out = 1'b1;
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt)
                    state_nx = aborted ? S_IDLE : S_NEXT;
            end
            S_NEXT: begin
                if (kind == K_POLL && idx != 3'd6) begin
                    step_poll = 1'b1;
                    state_nx  = S_ISSUE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            o_busy    <= 1'b0;
            gap_cnt   <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state     <= state_nx;
            o_busy    <= (state_nx != S_IDLE);
            gap_cnt   <= (state == S_GAP) ? ~gap_cnt : 1'b0;
            wr_done_q <= i_eng_wr_done;
            rd_done_q <= i_eng_rd_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind         <= K_INIT;
            cmd_wr       <= 1'b0;
            idx          <= 3'd0;
            aborted      <= 1'b0;
            shadow       <= '0;
            o_eng_addr   <= 5'd0;
            o_eng_rc     <= 1'b0;
            o_eng_wdata  <= 8'h00;
            o_host_ack   <= 1'b0;
            o_host_rdata <= 8'h00;
            o_time       <= '0;
            o_time_valid <= 1'b0;
        end else begin
            o_host_ack   <= 1'b0;
            o_time_valid <= 1'b0;
            if (state == S_INIT) begin
                kind        <= K_INIT;
                cmd_wr      <= 1'b1;
                aborted     <= 1'b0;
                o_eng_addr  <= 5'd7;
                o_eng_rc    <= 1'b0;
                o_eng_wdata <= 8'h00;
            end
            if (start_host) begin
                kind        <= K_HOST;
                cmd_wr      <= ~i_host_rd;
                aborted     <= 1'b0;
                o_eng_addr  <= i_host_addr;
                o_eng_rc    <= i_host_rc;
                o_eng_wdata <= i_host_wdata;
            end
            if (start_poll) begin
                kind        <= K_POLL;
                cmd_wr      <= 1'b0;
                aborted     <= 1'b0;
                idx         <= 3'd0;
                o_eng_addr  <= 5'd0;
                o_eng_rc    <= 1'b0;
                o_eng_wdata <= 8'h00;
            end
            if (step_poll) begin
                idx        <= idx + 3'd1;
                o_eng_addr <= {2'b00, idx + 3'd1};
            end
            if (done_hit && kind == K_HOST) begin
                o_host_ack <= 1'b1;
                if (!cmd_wr)
                    o_host_rdata <= i_eng_rd_data;
            end
            if (done_hit && kind == K_POLL && idx != 3'd6)
                shadow[idx] <= i_eng_rd_data;
            if (snap_load) begin
                o_time       <= {i_eng_rd_data, shadow};
                o_time_valid <= 1'b1;
            end
            if (time_out) begin
                aborted <= 1'b1;
                if (kind == K_HOST) begin
                    o_host_ack <= 1'b1;
                    if (!cmd_wr)
                        o_host_rdata <= 8'h00;
                end
            end
        end
    end

    // Tick stays armed through a burst; a disable takes effect once it ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else begin
            if (i_enable)
                poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            else if (!in_burst)
                poll_cnt <= '0;
            if (poll_wrap)
                poll_pend <= 1'b1;
            else if (start_poll || (!i_enable && !in_burst))
                poll_pend <= 1'b0;
        end
    end

`ifdef RTC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign wait_expired = (state == S_WAIT) &&
                          (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            o_err <= 1'b0;
        else if (time_out)
            o_err <= 1'b1;
        else if (snap_load)
            o_err <= 1'b0;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign wait_expired   = 1'b0;
    assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_ds1302_rtc_sequencer.sv
// Randomized bench for ds1302_rtc_sequencer against a register-file engine model.
// Expected snapshots and read data come from the bench's own DS1302 memory image.
module tb_ds1302_rtc_sequencer;

    localparam int POLL_DIV = 500;
    localparam int TIMEOUT  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_host_req = 1'b0;
    logic        i_host_rd = 1'b0;
    logic [4:0]  i_host_addr = 5'd0;
    logic        i_host_rc = 1'b0;
    logic [7:0]  i_host_wdata = 8'h00;
    logic        o_host_ack;
    logic [7:0]  o_host_rdata;
    logic        o_eng_wr_en, o_eng_rd_en;
    logic [4:0]  o_eng_addr;
    logic        o_eng_rc;
    logic [7:0]  o_eng_wdata;
    logic        i_eng_wr_done = 1'b0;
    logic        i_eng_rd_done = 1'b0;
    logic [7:0]  i_eng_rd_data = 8'hEE;
    logic [55:0] o_time;
    logic        o_time_valid, o_halted, o_busy, o_err;

    ds1302_rtc_sequencer #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable),
        .i_host_req(i_host_req), .i_host_rd(i_host_rd),
        .i_host_addr(i_host_addr), .i_host_rc(i_host_rc),
        .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack),
        .o_host_rdata(o_host_rdata), .o_eng_wr_en(o_eng_wr_en),
        .o_eng_rd_en(o_eng_rd_en), .o_eng_addr(o_eng_addr),
        .o_eng_rc(o_eng_rc), .o_eng_wdata(o_eng_wdata),
        .i_eng_wr_done(i_eng_wr_done), .i_eng_rd_done(i_eng_rd_done),
        .i_eng_rd_data(i_eng_rd_data), .o_time(o_time),
        .o_time_valid(o_time_valid), .o_halted(o_halted),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:63];
    logic [5:0] hist_key [$];
    bit         hist_wr  [$];

    int lat_cfg = 40, hold_cfg = 2;
    bit both_en = 0, spur_en = 0, silent = 0;
    int done_cyc = -1000, strobe_cyc = 0;
    int tv_cnt = 0, tv_cyc = 0, ack_cnt = 0, err_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Engine model: DS1302 register image behind a command/done handshake.
    initial begin
        bit pend, spur, m_wr;
        int m_lat, hold_cnt;
        logic [5:0] m_key;
        pend = 0; spur = 0; m_wr = 0; m_lat = 0; hold_cnt = 0; m_key = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 0; spur = 0; hold_cnt = 0;
                i_eng_wr_done = 0; i_eng_rd_done = 0; i_eng_rd_data = 8'hEE;
                continue;
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) begin
                    i_eng_wr_done = 0; i_eng_rd_done = 0;
                    i_eng_rd_data = 8'hEE;
                end
            end else if (spur) begin
                i_eng_wr_done = 0; i_eng_rd_done = 0; spur = 0;
            end
            if (o_eng_wr_en || o_eng_rd_en) begin
                check("eng_one_cmd", 64'(pend), 0);
                check("strobe_one_hot", 64'(o_eng_wr_en & o_eng_rd_en), 0);
                check("strobe_gap", 64'(cyc - done_cyc >= 4), 1);
                strobe_cyc = cyc;
                m_wr  = o_eng_wr_en;
                m_key = {o_eng_rc, o_eng_addr};
                m_lat = lat_cfg;
                if (m_wr) mem[m_key] = o_eng_wdata;
                hist_key.push_back(m_key);
                hist_wr.push_back(m_wr);
                if (!silent) pend = 1;
            end else if (pend) begin
                m_lat--;
                if (m_lat == 1 && spur_en && hold_cnt == 0) begin
                    if (m_wr) i_eng_rd_done = 1; else i_eng_wr_done = 1;
                    spur = 1;
                end
                if (m_lat <= 0) begin
                    pend = 0; spur = 0;
                    if (m_wr) begin
                        i_eng_wr_done = 1;
                        if (both_en) i_eng_rd_done = 1;
                    end else begin
                        i_eng_rd_done = 1;
                        i_eng_rd_data = mem[m_key];
                        if (both_en) i_eng_wr_done = 1;
                    end
                    hold_cnt = hold_cfg;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Snapshot/ack/error monitor.
    initial begin
        bit prev_tv, prev_err, ok;
        int n;
        prev_tv = 0; prev_err = 0;
        forever begin
            @(negedge clk);
            if (o_host_ack) ack_cnt++;
            if (o_err && !prev_err) err_cyc = cyc;
            prev_err = o_err;
            if (o_time_valid) begin
                tv_cnt++;
                tv_cyc = cyc;
                check("tv_pulse", 64'(prev_tv), 0);
                check("snapshot", 64'(o_time),
                      64'({mem[6], mem[5], mem[4], mem[3],
                           mem[2], mem[1], mem[0]}));
                check("halted", 64'(o_halted), 64'(mem[0][7]));
                n  = hist_key.size();
                ok = (n >= 7);
                for (int i = 0; i < 7 && ok; i++)
                    if (hist_key[n-7+i] != 6'(i) || hist_wr[n-7+i]) ok = 0;
                check("burst_order", 64'(ok), 1);
            end
            prev_tv = o_time_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic host_xfer(input bit rd, input logic [4:0] a, input bit rc,
                             input logic [7:0] d, output int ws);
        logic [7:0] exp;
        int t, a0;
        exp = silent ? 8'h00 : mem[{rc, a}];
        a0  = ack_cnt;
        i_host_rd = rd; i_host_addr = a; i_host_rc = rc; i_host_wdata = d;
        i_host_req = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_host_ack && t < 3000);
        ws = strobe_cyc;
        check("host_ack_seen", 64'(o_host_ack), 1);
        if (rd) check("host_rdata", 64'(o_host_rdata), 64'(exp));
        else if (!silent) check("host_wdata", 64'(mem[{rc, a}]), 64'(d));
        i_host_req = 0;
        repeat (6) @(negedge clk);
        check("host_one_ack", 64'(ack_cnt - a0), 1);
    endtask

    task automatic wait_strobe(input int key, input bit any, output bit ok);
        int hs, t;
        hs = hist_key.size(); t = 0; ok = 0;
        while (!ok && t < 2000) begin
            @(negedge clk);
            t++;
            if (hist_key.size() > hs) begin
                hs = hist_key.size();
                if (any || (hist_key[hs-1] == 6'(key) && !hist_wr[hs-1]))
                    ok = 1;
            end
        end
    endtask

    task automatic wait_tv(output bit ok);
        int t0, t;
        t0 = tv_cnt; t = 0;
        while (tv_cnt == t0 && t < 1500) begin
            @(negedge clk);
            t++;
        end
        ok = (tv_cnt != t0);
    endtask

    initial begin
        bit ok;
        int ws, rq, e, tv0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i] == 8'hEE) mem[i] = 8'h5A;
        end
        for (int i = 0; i < 7; i++) mem[i] = 8'h10 + 8'(i);
        mem[7] = 8'hA5;

        repeat (4) @(negedge clk);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_time", 64'(o_time), 0);
        check("rst_strobe", 64'({o_eng_wr_en, o_eng_rd_en}), 0);
        check("rst_ack_tv", 64'({o_host_ack, o_time_valid}), 0);
        check("rst_err_halt", 64'({o_err, o_halted}), 0);
        check("rst_rdata", 64'(o_host_rdata), 0);

        reset = 1;
        wait_strobe(0, 1, ok);
        check("init_strobe_seen", 64'(ok), 1);
        check("init_is_write", 64'(hist_wr[hist_wr.size()-1]), 1);
        check("init_key", 64'(hist_key[hist_key.size()-1]), 7);
        check("init_wp_data", 64'(mem[7]), 0);
        e = 0;
        while (done_cyc < 0 && e < 200) begin
            @(negedge clk);
            e++;
        end
        check("init_done_seen", 64'(done_cyc >= 0), 1);
        while (cyc < done_cyc + 3) @(negedge clk);
        check("init_busy_n3", 64'(o_busy), 1);
        @(negedge clk);
        check("init_busy_n4", 64'(o_busy), 0);

        lat_cfg = 3;
        i_enable = 1;
        wait_tv(ok);
        check("first_burst_seen", 64'(ok), 1);
        check("first_snapshot", 64'(o_time), 64'h16151413121110);
        check("first_halted", 64'(o_halted), 0);

        wait_strobe(0, 0, ok);
        check("burst_start_seen", 64'(ok), 1);
        rq = cyc;
        host_xfer(0, 5'd2, 0, 8'h23, ws);
        check("host_after_burst", 64'(tv_cyc > rq), 1);
        check("host_wr_after_tv", 64'(ws > tv_cyc), 1);

        host_xfer(0, 5'd0, 0, 8'h85, ws);
        host_xfer(1, 5'd0, 0, 8'h00, ws);
        check("rdata_85", 64'(o_host_rdata), 64'h85);
        wait_tv(ok);
        check("halt_burst_seen", 64'(ok), 1);
        check("halted_set", 64'(o_halted), 1);

        hold_cfg = 3;
        host_xfer(1, 5'($urandom_range(0, 31)), 1, 8'h00, ws);

        for (int k = 0; k < 24; k++) begin
            lat_cfg  = $urandom_range(1, 8);
            hold_cfg = $urandom_range(2, 4);
            both_en  = 1'($urandom_range(0, 1));
            spur_en  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 300)) @(negedge clk);
            host_xfer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 8'($urandom), ws);
        end

        wait_strobe(2, 0, ok);
        check("mid_burst_seen", 64'(ok), 1);
        tv0 = tv_cnt;
        reset = 0;
        repeat (3) @(negedge clk);
        check("rst_mid_time", 64'(o_time), 0);
        check("rst_mid_busy", 64'(o_busy), 0);
        mem[7] = 8'h3C;
        reset = 1;
        wait_strobe(0, 1, ok);
        check("rst_reinit_write", 64'(ok && hist_wr[hist_wr.size()-1]), 1);
        check("rst_reinit_key", 64'(hist_key[hist_key.size()-1]), 7);
        repeat (20) @(negedge clk);
        check("rst_no_tv", 64'(tv_cnt), 64'(tv0));

        i_enable = 0;
        repeat (200) @(negedge clk);
        tv0 = tv_cnt;
        repeat (1200) @(negedge clk);
        check("disabled_no_tv", 64'(tv_cnt), 64'(tv0));
        e = cyc;
        i_enable = 1;
        wait_tv(ok);
        check("reenable_burst", 64'(ok), 1);
        check("reenable_not_early", 64'(tv_cyc - e >= POLL_DIV), 1);
        check("reenable_not_late", 64'(tv_cyc - e <= POLL_DIV + 150), 1);

`ifdef RTC_SEQ_TIMEOUT_EN
        i_enable = 0;
        repeat (200) @(negedge clk);
        silent = 1;
        host_xfer(1, 5'd3, 0, 8'h00, ws);
        check("to_err_set", 64'(o_err), 1);
        check("to_err_cycle", 64'(err_cyc - ws), 101);
        repeat (4) @(negedge clk);
        check("to_idle", 64'(o_busy), 0);
        silent = 0;
        i_enable = 1;
        wait_tv(ok);
        check("to_recover_burst", 64'(ok), 1);
        check("to_err_cleared", 64'(o_err), 0);
`else
        check("err_tied_low", 64'(o_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
